clk_phase_ctrl: RTL

//  Controller/sequencer for the clk8f -> clk4f/clk2f/clkf divider chain feeding the mux/demux and

---
 rtl/clk_phase_pkg.sv | 23 ++
 rtl/clk_phase_ctrl_div.sv | 38 +++
 rtl/clk_phase_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/clk_phase_pkg.sv
// Shared types and constants for the clk8f divider sequencer.
// State encodings, counter width and strobe decode values.
package clk_phase_pkg;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // cnt[1:0] pattern that marks a clk2f rising edge
    localparam logic [1:0]       STB2F_PAT = 2'b10;
    // cnt value that marks a clkf rising edge
    localparam logic [CNT_W-1:0] STBF_VAL  = 3'd4;
    // cnt value just before a clkf rise (3 -> 4 edge)
    localparam logic [CNT_W-1:0] CNT_PRE_RISE = 3'd3;
    // last count of a clkf period (7 -> 0 edge)
    localparam logic [CNT_W-1:0] CNT_LAST  = 3'd7;

endpackage

// File: rtl/clk_phase_ctrl_div.sv
// Divider counter for clk8f: clocks come straight from flops,
// strobes are decoded from the same register with no extra latency.
module clk_div_counter
    import clk_phase_pkg::*;
(
    input  logic             clk8f,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] cnt,
    output logic             clk4f,
    output logic             clk2f,
    output logic             clkf,
    output logic             stb4f,
    output logic             stb2f,
    output logic             stbf
);

    // Free-running 3-bit count; clear has priority over advance
    always_ff @(posedge clk8f or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign clk4f = cnt[0];
    assign clk2f = cnt[1];
    assign clkf  = cnt[2];

    assign stb4f = cnt[0];
    assign stb2f = (cnt[1:0] == STB2F_PAT);
    assign stbf  = (cnt == STBF_VAL);

endmodule

// File: rtl/clk_phase_ctrl.sv
// Sequencer for the clk8f -> clk4f/clk2f/clkf divider chain:
// start, warm-up, drain to a full clkf period, re-phase on resync.
module clk_phase_ctrl
    import clk_phase_pkg::*;
#(
    parameter int WARMUP_CYCLES = 4,
    parameter int WCNT_W        = 4
) (
    input  logic       clk8f,
    input  logic       reset,
    input  logic       enable,
    input  logic       resync,
    output logic       clk4f,
    output logic       clk2f,
    output logic       clkf,
    output logic       stb4f,
    output logic       stb2f,
    output logic       stbf,
    output logic       ready,
    output logic [1:0] state
);

    localparam logic [WCNT_W-1:0] WARM_TGT = WCNT_W'(WARMUP_CYCLES);

    generate
        if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > (2**WCNT_W) - 1) begin : g_bad_warmup
            $error("clk_phase_ctrl: WARMUP_CYCLES out of range 1..2**WCNT_W-1");
        end
    endgenerate

    state_t            cur_state;
    state_t            nxt_state;
    logic [WCNT_W-1:0] warm_cnt;
    logic [WCNT_W-1:0] warm_nxt;
    logic [WCNT_W-1:0] warm_inc;
    logic              ready_nxt;
    logic              clear;
    logic              advance;
    logic [CNT_W-1:0]  cnt;

    assign warm_inc = warm_cnt + WCNT_W'(1);

    clk_div_counter u_div (
        .clk8f   (clk8f),
        .reset   (reset),
        .clear   (clear),
        .advance (advance),
        .cnt     (cnt),
        .clk4f   (clk4f),
        .clk2f   (clk2f),
        .clkf    (clkf),
        .stb4f   (stb4f),
        .stb2f   (stb2f),
        .stbf    (stbf)
    );

    // State, warm-up edge count and ready flag
    always_ff @(posedge clk8f or negedge reset) begin
        if (!reset) begin
            cur_state <= ST_IDLE;
            warm_cnt  <= '0;
            ready     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            warm_cnt  <= warm_nxt;
            ready     <= ready_nxt;
        end
    end

    // Next state, divider control and warm-up bookkeeping
    always_comb begin
        nxt_state = cur_state;
        warm_nxt  = warm_cnt;
        ready_nxt = ready;
        clear     = 1'b0;
        advance   = 1'b0;
        unique case (cur_state)
            ST_IDLE: begin
                clear = 1'b1;
                if (enable) begin
                    nxt_state = ST_WARMUP;
                    warm_nxt  = '0;
                end
            end
            ST_WARMUP, ST_RUN: begin
                if (!enable) begin
                    // stopping beats resync; finish the clkf period
                    nxt_state = ST_DRAIN;
                    ready_nxt = 1'b0;
                    advance   = 1'b1;
                end else if (resync) begin
                    nxt_state = ST_WARMUP;
                    warm_nxt  = '0;
                    ready_nxt = 1'b0;
                    clear     = 1'b1;
                end else begin
                    advance = 1'b1;
                    if (cur_state == ST_WARMUP && cnt == CNT_PRE_RISE) begin
                        warm_nxt = warm_inc;
                        if (warm_inc == WARM_TGT) begin
                            nxt_state = ST_RUN;
                            ready_nxt = 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                advance   = 1'b1;
                ready_nxt = 1'b0;
                if (cnt == CNT_LAST) begin
                    nxt_state = ST_IDLE;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase
    end

    assign state = cur_state;

endmodule
